instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL run on one clock and use synchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (synchronous active-low reset).
REQ-002 The block SHALL provide control ports: start in 1 (begin program load); base_addr in 8 (first memory address); count in 9 (instructions to load, 0..256); busy out 1 (load in progress); done out 1 (one-cycle completion pulse).
REQ-003 The block SHALL provide field-input ports: in_valid in 1; in_ready out 1; in_opcode in 5; in_rs in 4; in_rt in 4; in_rd in 4; in_imm in 8.
REQ-004 The block SHALL provide memory-write ports: mem_we out 1; mem_addr out 8; mem_wdata out 17; mem_ready in 1 (write accepted when mem_we && mem_ready).
REQ-005 The block SHALL provide imm_err out 1 (sticky immediate truncation flag).

Function
REQ-006 Encoding SHALL be selected by opcode only. R-type (opcode < 7): {opcode, rs, rt, rd}; imm ignored.
REQ-007 I-type-high (opcode[4]=1): {opcode, imm[3:0], rt, rd}; rs ignored.
REQ-008 I-type-low (7 <= opcode <= 15): {opcode, rd, rt, imm[3:0]}; rs ignored.
REQ-009 States SHALL be IDLE and RUN. IDLE->RUN on start; start SHALL be ignored in RUN.
REQ-010 start with count=0 SHALL pulse done the next cycle and stay in IDLE; no write occurs.
REQ-011 In RUN, in_ready = FIFO not full && accepted < count; in IDLE, in_ready = 0.
REQ-012 A handshake (in_valid && in_ready) SHALL push the encoded word into a 2-entry FIFO; the word SHALL appear on mem_wdata with mem_we=1 no earlier than the next cycle (no combinational pass-through).
REQ-013 mem_we = FIFO not empty; mem_wdata = FIFO head; the head SHALL pop only on mem_we && mem_ready.
REQ-014 mem_addr SHALL load base_addr on start, increment by 1 per completed write, and wrap 8'hFF -> 8'h00 without error.
REQ-015 Simultaneous push and pop SHALL be supported; FIFO order SHALL be preserved.
REQ-016 On the cycle after the count-th write completes, done SHALL pulse for one cycle, busy SHALL drop, and the state SHALL return to IDLE.
REQ-017 busy = 1 exactly while in RUN.
REQ-018 imm_err SHALL set on acceptance of an I-type (either form) with imm[7:4] != 0, SHALL clear on an accepted start, and SHALL otherwise hold.

Reset
REQ-019 With rst_n=0 at a clk edge: state IDLE, FIFO empty, counters 0, mem_addr 0, and in_ready, mem_we, busy, done, imm_err all 0. mem_wdata SHALL be 0.
REQ-020 Reset mid-RUN SHALL abort the load, flush the FIFO, issue no done pulse, and assert no mem_we from the first cycle after reset.

Structure
REQ-021 Shared package instr_pkg SHALL hold OPCODE_W=5, REG_W=4, INSTR_W=17, field bit positions, R_TYPE_LIMIT=7, and the format enum {FMT_R, FMT_I_HI, FMT_I_LO}; the decoder SHALL share the package.
REQ-022 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH=17, DEPTH=2); the encode function and FSM SHALL reside in instruction_encoder.

Verification
REQ-023 R-type: base 8'h10, count 1, opcode 5'h02, rs 3, rt 4, rd 5 -> one write 17'h02345 at 8'h10, done pulse, imm_err 0.
REQ-024 I-type-high: opcode 5'h11, imm 8'h0A, rt 2, rd 3, rs 9 -> 17'h11A23, imm_err 0.
REQ-025 I-type-low: opcode 5'h08, rd 7, rt 1, imm 8'h1C -> 17'h0871C, imm_err 1.
REQ-026 Backpressure: count 4, mem_ready low 5 cycles -> in_ready drops after 2 accepts; writes in order at base..base+3; done only after the 4th write.
REQ-027 Wrap: base 8'hFE, count 3 -> mem_addr FE, FF, 00.
REQ-028 Reset mid-run: rst_n low after 2 of 4 writes -> all outputs 0 next cycle, no further mem_we, no done pulse.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg: field widths, bit positions and format decode shared by the encoder and its decoder peers.
package instr_pkg;
    localparam int OPCODE_W = 5;
    localparam int REG_W = 4;
    localparam int IMM_W = 8;
    localparam int INSTR_W = 17;
    localparam int ADDR_W = 8;
    localparam int CNT_W = 9;
    localparam int OP_LSB = 12;
    localparam int F2_LSB = 8;
    localparam int F1_LSB = 4;
    localparam int F0_LSB = 0;
    localparam logic [OPCODE_W-1:0] R_TYPE_LIMIT = 5'd7;
    typedef enum logic [1:0] {FMT_R, FMT_I_HI, FMT_I_LO} fmt_e;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    // Opcodes 7..15 fall through to the low I-type form.
    function automatic fmt_e decode_fmt(input logic [OPCODE_W-1:0] op);
        return (op < R_TYPE_LIMIT) ? FMT_R : (op[OPCODE_W-1] ? FMT_I_HI : FMT_I_LO);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO; data reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_we, w_re;
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign w_we = i_push && !o_full;
    assign w_re = i_pop && !o_empty;
    assign o_full = (r_cnt == (AW + 1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_we) r_mem[r_wr] <= i_data;
            if (w_we) r_wr <= ptr_inc(r_wr);
            if (w_re) r_rd <= ptr_inc(r_rd);
            r_cnt <= r_cnt + (AW + 1)'(w_we) - (AW + 1)'(w_re);
        end
    end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs instruction fields into 17-bit words and streams them to memory
// through a 2-entry FIFO, counting accepts and writes until the requested program length is loaded.
module instruction_encoder
    import instr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [IMM_W-1:0]    in_imm,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    input  logic                mem_ready,
    output logic                imm_err
);
    state_e r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0] r_count, r_accepted, r_written;
    logic r_done, r_imm_err, w_done_next;
    logic w_full, w_empty, w_push, w_pop, w_start_acc;
    fmt_e w_fmt;
    logic [INSTR_W-1:0] w_word;
    function automatic logic [INSTR_W-1:0] encode(
        input logic [OPCODE_W-1:0] op,
        input logic [REG_W-1:0]    rs,
        input logic [REG_W-1:0]    rt,
        input logic [REG_W-1:0]    rd,
        input logic [IMM_W-1:0]    imm
    );
        logic [INSTR_W-1:0] w;
        fmt_e f;
        f = decode_fmt(op);
        w[OP_LSB +: OPCODE_W] = op;
        w[F2_LSB +: REG_W] = (f == FMT_R) ? rs : ((f == FMT_I_HI) ? imm[REG_W-1:0] : rd);
        w[F1_LSB +: REG_W] = rt;
        w[F0_LSB +: REG_W] = (f == FMT_I_LO) ? imm[REG_W-1:0] : rd;
        return w;
    endfunction
    assign w_fmt = decode_fmt(in_opcode);
    assign w_word = encode(in_opcode, in_rs, in_rt, in_rd, in_imm);
    assign w_start_acc = start && (r_state == ST_IDLE);
    assign in_ready = (r_state == ST_RUN) && !w_full && (r_accepted < r_count);
    assign w_push = in_valid && in_ready;
    assign w_pop = !w_empty && mem_ready;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign mem_we = !w_empty;
    assign mem_addr = r_addr;
    assign imm_err = r_imm_err;
    sync_fifo #(.WIDTH(INSTR_W), .DEPTH(2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (mem_wdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_comb begin
        w_state_next = r_state;
        w_done_next = 1'b0;
        if (r_state == ST_IDLE) begin
            w_state_next = (start && count != '0) ? ST_RUN : ST_IDLE;
            w_done_next = start && (count == '0);
        end else if (w_pop && (r_written + 1'b1 == r_count)) begin
            w_state_next = ST_IDLE;
            w_done_next = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done <= 1'b0;
            r_addr <= '0;
            r_count <= '0;
            r_accepted <= '0;
            r_written <= '0;
            r_imm_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done <= w_done_next;
            if (w_start_acc) begin
                r_addr <= base_addr;
                r_count <= count;
                r_accepted <= '0;
                r_written <= '0;
                r_imm_err <= 1'b0;
            end else begin
                if (w_push) r_accepted <= r_accepted + 1'b1;
                if (w_pop) r_written <= r_written + 1'b1;
                if (w_pop) r_addr <= r_addr + 1'b1;
                if (w_push && w_fmt != FMT_R && in_imm[IMM_W-1:REG_W] != '0) r_imm_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed scenarios with hand-computed words, addresses and flags.
module tb_instruction_encoder;
    logic clk = 1'b0, rst_n, start, busy, done, in_valid, in_ready, mem_we, mem_ready, imm_err;
    logic [7:0] base_addr, mem_addr, in_imm;
    logic [8:0] count;
    logic [4:0] in_opcode;
    logic [3:0] in_rs, in_rt, in_rd;
    logic [16:0] mem_wdata;
    int n_vec = 0, n_err = 0;

    instruction_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .imm_err(imm_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [3:0] rs, rt, rd, input logic [7:0] imm);
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    endtask

    // Loads one instruction with mem_ready high and reports what was written.
    task automatic load_one(input logic [7:0] base, output logic [16:0] w, output logic [7:0] a,
                            output logic got_done);
        logic hs;
        w = 'x; a = 'x; got_done = 1'b0;
        base_addr = base; count = 9'd1; start = 1'b1; in_valid = 1'b1; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hs = in_valid && in_ready;
            if (mem_we && mem_ready) begin w = mem_wdata; a = mem_addr; end
            tick();
            if (hs) in_valid = 1'b0;
            if (done) begin got_done = 1'b1; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; base_addr = 0; count = 0; in_valid = 0; mem_ready = 0;
        set_fields(0, 0, 0, 0, 0);
        tick(); tick();
        n_vec++; if ({busy, done, in_ready, mem_we, imm_err} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b want=00000", {busy, done, in_ready, mem_we, imm_err}); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h want=00", mem_addr); end
        n_vec++; if (mem_wdata !== 17'h0) begin n_err++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_r_type();
        logic [16:0] w; logic [7:0] a; logic d;
        set_fields(5'h02, 4'd3, 4'd4, 4'd5, 8'hF0);
        load_one(8'h10, w, a, d);
        n_vec++; if (w !== 17'h02345) begin n_err++; $display("FAIL r_word got=%h want=02345", w); end
        n_vec++; if (a !== 8'h10) begin n_err++; $display("FAIL r_addr got=%h want=10", a); end
        n_vec++; if (d !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL r_done got done=%b busy=%b want done=1 busy=0", d, busy); end
        n_vec++; if (imm_err !== 1'b0) begin n_err++; $display("FAIL r_imm_err got=%b want=0", imm_err); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL r_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_i_hi();
        logic [16:0] w; logic [7:0] a; logic d;
        set_fields(5'h11, 4'd9, 4'd2, 4'd3, 8'h0A);
        load_one(8'h33, w, a, d);
        n_vec++; if (w !== 17'h11A23) begin n_err++; $display("FAIL ihi_word got=%h want=11a23", w); end
        n_vec++; if (a !== 8'h33 || d !== 1'b1) begin n_err++; $display("FAIL ihi_addr_done got=%h/%b want=33/1", a, d); end
        n_vec++; if (imm_err !== 1'b0) begin n_err++; $display("FAIL ihi_imm_err got=%b want=0", imm_err); end
        tick();
    endtask

    task automatic test_i_lo();
        logic [16:0] w; logic [7:0] a; logic d;
        set_fields(5'h08, 4'd0, 4'd1, 4'd7, 8'h1C);
        load_one(8'h50, w, a, d);
        n_vec++; if (w !== 17'h0871C) begin n_err++; $display("FAIL ilo_word got=%h want=0871c", w); end
        n_vec++; if (a !== 8'h50 || d !== 1'b1) begin n_err++; $display("FAIL ilo_addr_done got=%h/%b want=50/1", a, d); end
        n_vec++; if (imm_err !== 1'b1) begin n_err++; $display("FAIL ilo_imm_err got=%b want=1", imm_err); end
        tick(); tick();
        n_vec++; if (imm_err !== 1'b1) begin n_err++; $display("FAIL ilo_imm_err_hold got=%b want=1", imm_err); end
    endtask

    task automatic test_count_zero();
        base_addr = 8'h77; count = 9'd0; start = 1'b1; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if ({done, busy, mem_we, in_ready} !== 4'b1000) begin n_err++; $display("FAIL zero_pulse got=%b want=1000", {done, busy, mem_we, in_ready}); end
        n_vec++; if (imm_err !== 1'b0) begin n_err++; $display("FAIL zero_imm_clear got=%b want=0", imm_err); end
        tick();
        n_vec++; if ({done, busy, mem_we} !== 3'b000) begin n_err++; $display("FAIL zero_after got=%b want=000", {done, busy, mem_we}); end
    endtask

    task automatic test_backpressure();
        logic [16:0] exp_w [4];
        logic [4:0] ops [4];
        logic [3:0] rss [4], rts [4], rds [4];
        logic [7:0] imms [4];
        int idx, k;
        logic hs, finished;
        ops = '{5'h01, 5'h10, 5'h0F, 5'h07}; rss = '{4'h1, 4'hF, 4'h0, 4'h0};
        rts = '{4'h2, 4'h6, 4'h9, 4'hB};     rds = '{4'h3, 4'h7, 4'h8, 4'hC};
        imms = '{8'hFF, 8'h05, 8'h0A, 8'h03};
        exp_w = '{17'h01123, 17'h10567, 17'h0F89A, 17'h07CB3};
        idx = 0; k = 0; finished = 0;
        base_addr = 8'h20; count = 9'd4; start = 1'b1; mem_ready = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        set_fields(ops[0], rss[0], rts[0], rds[0], imms[0]);
        for (int c = 0; c < 5; c++) begin
            hs = in_valid && in_ready;
            tick();
            if (hs) begin idx++; if (idx < 4) set_fields(ops[idx], rss[idx], rts[idx], rds[idx], imms[idx]); end
        end
        n_vec++; if (in_ready !== 1'b0 || idx != 2) begin n_err++; $display("FAIL bp_stall got ready=%b accepts=%0d want ready=0 accepts=2", in_ready, idx); end
        n_vec++; if (mem_we !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL bp_hold got we=%b done=%b want we=1 done=0", mem_we, done); end
        mem_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            hs = in_valid && in_ready;
            if (mem_we && mem_ready) begin
                n_vec++; if (k > 3 || mem_wdata !== exp_w[k & 3] || mem_addr !== 8'h20 + 8'(k)) begin
                    n_err++; $display("FAIL bp_write%0d got %h@%h want %h@%h", k, mem_wdata, mem_addr, exp_w[k & 3], 8'h20 + 8'(k)); end
                k++;
            end
            tick();
            if (hs) begin idx++; if (idx < 4) set_fields(ops[idx], rss[idx], rts[idx], rds[idx], imms[idx]); else in_valid = 1'b0; end
            if (done) begin finished = 1; break; end
        end
        in_valid = 1'b0;
        n_vec++; if (!finished || k != 4 || busy !== 1'b0) begin n_err++; $display("FAIL bp_done got done=%b writes=%0d busy=%b want 1/4/0", finished, k, busy); end
        n_vec++; if (imm_err !== 1'b0) begin n_err++; $display("FAIL bp_imm_err got=%b want=0", imm_err); end
        tick();
    endtask

    task automatic test_wrap();
        logic [16:0] exp_w [3];
        logic [7:0] exp_a [3];
        logic [4:0] ops [3];
        logic [3:0] rss [3], rts [3], rds [3];
        logic [7:0] imms [3];
        int idx, k;
        logic hs, finished;
        ops = '{5'h06, 5'h00, 5'h1F}; rss = '{4'h1, 4'h0, 4'h0}; rts = '{4'h2, 4'h0, 4'h4};
        rds = '{4'h3, 4'h0, 4'h5};    imms = '{8'h00, 8'h00, 8'h0E};
        exp_w = '{17'h06123, 17'h00000, 17'h1FE45};
        exp_a = '{8'hFE, 8'hFF, 8'h00};
        idx = 0; k = 0; finished = 0;
        base_addr = 8'hFE; count = 9'd3; start = 1'b1; mem_ready = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        set_fields(ops[0], rss[0], rts[0], rds[0], imms[0]);
        for (int c = 0; c < 30; c++) begin
            hs = in_valid && in_ready;
            if (mem_we && mem_ready) begin
                n_vec++; if (k > 2 || mem_wdata !== exp_w[k % 3] || mem_addr !== exp_a[k % 3]) begin
                    n_err++; $display("FAIL wrap_write%0d got %h@%h want %h@%h", k, mem_wdata, mem_addr, exp_w[k % 3], exp_a[k % 3]); end
                k++;
            end
            tick();
            if (hs) begin idx++; if (idx < 3) set_fields(ops[idx], rss[idx], rts[idx], rds[idx], imms[idx]); else in_valid = 1'b0; end
            if (done) begin finished = 1; break; end
        end
        in_valid = 1'b0;
        n_vec++; if (!finished || k != 3 || mem_addr !== 8'h01) begin n_err++; $display("FAIL wrap_done got done=%b writes=%0d addr=%h want 1/3/01", finished, k, mem_addr); end
        tick();
    endtask

    task automatic test_reset_mid();
        int wr;
        logic hs, bad;
        wr = 0; bad = 0;
        base_addr = 8'h40; count = 9'd4; start = 1'b1; mem_ready = 1'b1;
        set_fields(5'h03, 4'h1, 4'h1, 4'h1, 8'h00);
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20 && wr < 2; c++) begin
            hs = mem_we && mem_ready;
            tick();
            if (hs) wr++;
        end
        n_vec++; if (wr != 2 || busy !== 1'b1) begin n_err++; $display("FAIL mid_progress got writes=%0d busy=%b want 2/1", wr, busy); end
        rst_n = 1'b0;
        tick();
        n_vec++; if ({busy, done, in_ready, mem_we, imm_err} !== 5'b0 || mem_addr !== 8'h00 || mem_wdata !== 17'h0) begin
            n_err++; $display("FAIL mid_reset got flags=%b addr=%h data=%h want 0/00/0", {busy, done, in_ready, mem_we, imm_err}, mem_addr, mem_wdata); end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_we || done || busy) bad = 1;
        end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL mid_quiet got activity=%b want=0", bad); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_hi();
        test_i_lo();
        test_count_zero();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
